// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment pattern constants, state encoding and defaults
package seg7_pkg;

    localparam int STABLE_CYCLES_DEFAULT = 4;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [1:0] AN_BLANK  = 2'b11;
    localparam logic [1:0] AN_UNITS  = 2'b10;
    localparam logic [1:0] AN_TENS   = 2'b01;

    // Active-low a..g, bit6 = a, bit0 = g
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    typedef enum logic [1:0] {
        S_UNITS = 2'd0,
        S_TENS  = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    // Only meaningful for legal digits, where the result never exceeds 99
    function automatic logic [6:0] tens_units_to_bin(input logic [3:0] tens, input logic [3:0] units);
        return {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, units};
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational active-low a..g pattern to decimal digit lookup
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] digit_o,
    output logic       illegal_o
);

    always_comb begin
        digit_o   = 4'd0;
        illegal_o = 1'b0;
        case (seg_i)
            SEG_0:   digit_o = 4'd0;
            SEG_1:   digit_o = 4'd1;
            SEG_2:   digit_o = 4'd2;
            SEG_3:   digit_o = 4'd3;
            SEG_4:   digit_o = 4'd4;
            SEG_5:   digit_o = 4'd5;
            SEG_6:   digit_o = 4'd6;
            SEG_7:   digit_o = 4'd7;
            SEG_8:   digit_o = 4'd8;
            SEG_9:   digit_o = 4'd9;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_decode_rx.sv
// rtl/seg7_decode_rx.sv - recovers a two-digit value from a multiplexed seven-segment display
module seg7_decode_rx
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter bit CHANGE_ONLY   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_n,
    input  logic [1:0] an_n,
    output logic [6:0] out_value,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun
);

    // The counter compares against the previous sample, so STABLE_CYCLES identical
    // samples correspond to STABLE_CYCLES-1 matching compares.
    localparam logic [7:0] CNT_SAT = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_ACC = 8'(STABLE_CYCLES - 2);

    logic [9:0] samp_q;
    logic [9:0] prev_q;
    logic [7:0] cnt_q, cnt_d;
    state_t     state_q, state_d;
    logic [3:0] units_q, units_d;
    logic [3:0] tens_q, tens_d;
    logic       units_ill_q, units_ill_d;
    logic       tens_ill_q, tens_ill_d;
    logic [6:0] out_value_q, out_value_d;
    logic       out_valid_q, out_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;
    logic       last_vld_q, last_vld_d;
    logic [6:0] last_val_q, last_val_d;

    logic [1:0] samp_an;
    logic       is_digit;
    logic       same;
    logic       accept;
    logic [3:0] dec_digit;
    logic       dec_illegal;
    logic [6:0] emit_val;
    logic       frame_ill;
    logic       is_repeat;
    logic       do_load;
    logic       unused_dp;

    assign samp_an   = samp_q[9:8];
    assign is_digit  = (samp_an == AN_UNITS) || (samp_an == AN_TENS);
    assign same      = (samp_q[9:1] == prev_q[9:1]);
    assign accept    = is_digit && same && (cnt_q == CNT_ACC);
    assign unused_dp = samp_q[0] ^ prev_q[0];

    seg7_to_bcd u_seg7_to_bcd (
        .seg_i     (samp_q[7:1]),
        .digit_o   (dec_digit),
        .illegal_o (dec_illegal)
    );

    assign emit_val  = tens_units_to_bin(tens_q, units_q);
    assign frame_ill = units_ill_q | tens_ill_q;
    assign is_repeat = CHANGE_ONLY && last_vld_q && (last_val_q == emit_val);
    assign do_load   = (state_q == S_EMIT) && !frame_ill && !is_repeat;

    always_comb begin
        cnt_d = cnt_q;
        if (!is_digit || !same) begin
            cnt_d = 8'd0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        units_d     = units_q;
        tens_d      = tens_q;
        units_ill_d = units_ill_q;
        tens_ill_d  = tens_ill_q;
        case (state_q)
            S_UNITS: begin
                if (accept && samp_an == AN_UNITS) begin
                    units_d     = dec_digit;
                    units_ill_d = dec_illegal;
                    state_d     = S_TENS;
                end
            end
            S_TENS: begin
                if (accept && samp_an == AN_TENS) begin
                    tens_d     = dec_digit;
                    tens_ill_d = dec_illegal;
                    state_d    = S_EMIT;
                end
            end
            S_EMIT:  state_d = S_UNITS;
            default: state_d = S_UNITS;
        endcase
    end

    always_comb begin
        out_value_d = out_value_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        last_vld_d  = last_vld_q;
        last_val_d  = last_val_q;
        frame_err_d = (state_q == S_EMIT) && frame_ill;
        if (do_load) begin
            out_value_d = emit_val;
            out_valid_d = 1'b1;
            last_vld_d  = 1'b1;
            last_val_d  = emit_val;
            if (out_valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q      <= {AN_BLANK, SEG_BLANK};
            prev_q      <= {AN_BLANK, SEG_BLANK};
            cnt_q       <= 8'd0;
            state_q     <= S_UNITS;
            units_q     <= 4'd0;
            tens_q      <= 4'd0;
            units_ill_q <= 1'b0;
            tens_ill_q  <= 1'b0;
            out_value_q <= 7'd0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            last_vld_q  <= 1'b0;
            last_val_q  <= 7'd0;
        end else begin
            samp_q      <= {an_n, seg_n};
            prev_q      <= samp_q;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            units_q     <= units_d;
            tens_q      <= tens_d;
            units_ill_q <= units_ill_d;
            tens_ill_q  <= tens_ill_d;
            out_value_q <= out_value_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            last_vld_q  <= last_vld_d;
            last_val_q  <= last_val_d;
        end
    end

    assign out_value = out_value_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_decode_rx.sv
// tb/tb_seg7_decode_rx.sv - scoreboard testbench for seg7_decode_rx
module tb_seg7_decode_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg_n;
    logic [1:0] an_n;
    logic [6:0] out_value;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int hs_cnt = 0;
    int err_cnt = 0;
    int bench_last = -1;
    logic [6:0] exp_q[$];

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    always #5 clk = ~clk;

    seg7_decode_rx #(.STABLE_CYCLES(4), .CHANGE_ONLY(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .out_value (out_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) err_cnt++;
            if (out_valid && out_ready) begin
                logic [6:0] exp_v;
                hs_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL scoreboard_unexpected: out_value=%0d, required no output", out_value);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (out_value !== exp_v) begin
                        n_bad++;
                        $display("FAIL scoreboard_value: out_value=%0d, required %0d", out_value, exp_v);
                    end
                end
            end
        end
    end

    task automatic drive(input logic [1:0] an, input logic [6:0] seg, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            an_n  = an;
            seg_n = {seg, 1'($urandom_range(0, 1))};
        end
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            an_n  = 2'b11;
            seg_n = 8'hFF;
        end
    endtask

    task automatic frame(input int u, input int t);
        int v;
        v = t * 10 + u;
        if (v != bench_last) begin
            exp_q.push_back(7'(v));
            bench_last = v;
        end
        drive(2'b10, seg_tab[u], 6);
        drive(2'b01, seg_tab[t], 6);
    endtask

    task automatic test_reset();
        rst = 1'b1; an_n = 2'b11; seg_n = 8'hFF; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp += 4;
        if (out_value !== 7'd0) begin n_bad++; $display("FAIL reset_value: got %0d, required 0", out_value); end
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
        if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
        @(posedge clk); #1;
        rst = 1'b0;
        bench_last = -1;
    endtask

    task automatic test_basic_42();
        int h0;
        h0 = hs_cnt;
        frame(2, 4);
        blank(8);
        @(negedge clk);
        n_cmp += 2;
        if (hs_cnt !== h0 + 1) begin n_bad++; $display("FAIL basic_count: got %0d outputs, required 1", hs_cnt - h0); end
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL basic_overrun: got %b, required 0", overrun); end
    endtask

    task automatic test_short_hold();
        int h0, e0;
        h0 = hs_cnt; e0 = err_cnt;
        drive(2'b10, seg_tab[7], 3);
        blank(10);
        drive(2'b01, seg_tab[1], 6);
        blank(8);
        @(negedge clk);
        n_cmp += 2;
        if (hs_cnt !== h0) begin n_bad++; $display("FAIL short_hold_count: got %0d outputs, required 0", hs_cnt - h0); end
        if (err_cnt !== e0) begin n_bad++; $display("FAIL short_hold_err: got %0d pulses, required 0", err_cnt - e0); end
    endtask

    task automatic test_illegal();
        int h0, e0;
        h0 = hs_cnt; e0 = err_cnt;
        drive(2'b10, 7'b1111000, 6);
        drive(2'b01, seg_tab[3], 6);
        blank(8);
        @(negedge clk);
        n_cmp += 3;
        if (err_cnt !== e0 + 1) begin n_bad++; $display("FAIL illegal_err: got %0d pulses, required 1", err_cnt - e0); end
        if (hs_cnt !== h0) begin n_bad++; $display("FAIL illegal_count: got %0d outputs, required 0", hs_cnt - h0); end
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL illegal_valid: got %b, required 0", out_valid); end
    endtask

    task automatic test_overrun();
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(2'b10, seg_tab[2], 6);
        drive(2'b01, seg_tab[1], 6);
        exp_q.push_back(7'd37);
        bench_last = 37;
        drive(2'b10, seg_tab[7], 6);
        drive(2'b01, seg_tab[3], 6);
        blank(8);
        @(negedge clk);
        n_cmp += 3;
        if (out_value !== 7'd37) begin n_bad++; $display("FAIL overrun_value: got %0d, required 37", out_value); end
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL overrun_valid: got %b, required 1", out_valid); end
        if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_flag: got %b, required 1", overrun); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        n_cmp += 2;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL overrun_drain: got %b, required 0", out_valid); end
        if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_sticky: got %b, required 1", overrun); end
    endtask

    task automatic test_mid_reset();
        int h0;
        drive(2'b10, seg_tab[5], 6);
        @(posedge clk); #1;
        rst = 1'b1; an_n = 2'b11; seg_n = 8'hFF;
        @(posedge clk); #1;
        rst = 1'b0;
        bench_last = -1;
        h0 = hs_cnt;
        @(negedge clk);
        n_cmp += 3;
        if (out_value !== 7'd0) begin n_bad++; $display("FAIL midreset_value: got %0d, required 0", out_value); end
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid: got %b, required 0", out_valid); end
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL midreset_overrun: got %b, required 0", overrun); end
        drive(2'b01, seg_tab[3], 6);
        blank(8);
        @(negedge clk);
        n_cmp += 2;
        if (hs_cnt !== h0) begin n_bad++; $display("FAIL midreset_count: got %0d outputs, required 0", hs_cnt - h0); end
        if (out_value !== 7'd0) begin n_bad++; $display("FAIL midreset_after: got %0d, required 0", out_value); end
    endtask

    task automatic test_change_only();
        int h0;
        h0 = hs_cnt;
        for (int i = 0; i < 3; i++) frame(2, 4);
        blank(8);
        @(negedge clk);
        n_cmp++;
        if (hs_cnt !== h0 + 1) begin n_bad++; $display("FAIL change_only_count: got %0d outputs, required 1", hs_cnt - h0); end
    endtask

    task automatic test_back_to_back();
        int vals[$] = '{99, 0, 0, 10, 9, 55, 55};
        int h0, pushed, v;
        h0 = hs_cnt; pushed = 0;
        for (int i = 0; i < 4; i++) begin
            do v = int'($urandom_range(0, 99)); while (v == vals[vals.size() - 1]);
            vals.push_back(v);
        end
        foreach (vals[i]) begin
            if (vals[i] != bench_last) pushed++;
            frame(vals[i] % 10, vals[i] / 10);
        end
        blank(8);
        @(negedge clk);
        n_cmp++;
        if (hs_cnt !== h0 + pushed) begin n_bad++; $display("FAIL b2b_count: got %0d outputs, required %0d", hs_cnt - h0, pushed); end
    endtask

    initial begin
        test_reset();
        test_basic_42();
        test_short_hold();
        test_illegal();
        test_overrun();
        test_mid_reset();
        test_change_only();
        test_back_to_back();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover: %0d outputs never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_decode_rx.md
SEG7_DECODE_RX -- requirements
Module: seg7_decode_rx

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, consecutive identical samples needed to accept a digit (range 2..255).
REQ-002 SHALL have parameter CHANGE_ONLY, default 1; 1 = emit only when the value differs from the last emitted value.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port seg_n  input  8  active-low segments, bit7=a .. bit1=g, bit0=dp.
REQ-006 SHALL have port an_n  input  2  active-low digit select, bit0=units, bit1=tens.
REQ-007 SHALL have port out_value  output  7  decoded value 0..99, binary.
REQ-008 SHALL have port out_valid  output  1  out_value holds an unconsumed frame.
REQ-009 SHALL have port out_ready  input  1  consumer accepts when out_valid&out_ready.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a frame with an illegal digit.
REQ-011 SHALL have port overrun  output  1  sticky; a pending frame was overwritten.

Function
REQ-012 SHALL register {an_n, seg_n} once, then compare each registered sample with the previous registered sample.
REQ-013 SHALL hold a saturating stability counter: cleared on sample change, incremented otherwise, saturating at STABLE_CYCLES.
REQ-014 SHALL accept a digit on the edge where the same sample has been present for STABLE_CYCLES consecutive registered cycles.
REQ-015 SHALL ignore dp (bit0) for decoding and for stability comparison.
REQ-016 SHALL treat an_n=2'b11 (blank) and an_n=2'b00 (both digits) as non-digit samples: counter cleared, nothing accepted.
REQ-017 SHALL decode a-g patterns 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9; any other pattern is illegal.
REQ-018 SHALL implement states S_UNITS, S_TENS and S_EMIT; reset enters S_UNITS.
REQ-019 S_UNITS: on acceptance with an_n=2'b10, SHALL latch the units digit and its illegal flag, then go to S_TENS; acceptances of tens are ignored.
REQ-020 S_TENS: on acceptance with an_n=2'b01, SHALL latch the tens digit and its illegal flag, then go to S_EMIT; units acceptances are ignored.
REQ-021 S_EMIT: SHALL last exactly one cycle and then return to S_UNITS.
REQ-022 In S_EMIT with either digit illegal, SHALL pulse frame_err for one cycle and leave out_value, out_valid and the last-emitted record unchanged.
REQ-023 In S_EMIT with both digits legal, SHALL compute tens*10+units in 7 bits; result is never above 99.
REQ-024 SHALL drop the frame silently when CHANGE_ONLY=1 and the result equals the last emitted value; the first frame after reset always emits.
REQ-025 SHALL load out_value and set out_valid on the edge leaving S_EMIT, giving 1-cycle latency from tens acceptance.
REQ-026 SHALL clear out_valid on the edge where out_valid&out_ready, unless a new frame loads on that same edge; then out_valid stays 1 and there is no overrun.
REQ-027 SHALL overwrite out_value and set overrun when loading while out_valid=1 and out_ready=0; overrun clears only on reset.
REQ-028 SHALL keep out_value stable while out_valid=1 except at a REQ-027 overwrite.

Reset
REQ-029 On rst=1 at a clock edge, SHALL set out_value=0, out_valid=0, frame_err=0, overrun=0, stability counter=0, sample register=8'hFF/2'b11, latched digits=0, last-emitted record invalid, state=S_UNITS.
REQ-030 A reset mid-frame SHALL discard any latched digit; no frame completes from pre-reset samples.

Structure
REQ-031 SHALL place the segment pattern constants, the blank pattern 8'hFF, the state encoding and the STABLE_CYCLES default in shared package seg7_pkg.
REQ-032 SHALL put the pattern lookup in combinational sub-module seg7_to_bcd (7-bit a-g in; 4-bit digit and illegal flag out), shared with future seg7 blocks.

Verification
REQ-033 Units 0010010 (an_n=10) for 6 cycles, then tens 1001100 (an_n=01) for 6 cycles, out_ready=1 -> out_value=42 and out_valid high 1 cycle after tens acceptance.
REQ-034 Units pattern held 3 cycles with STABLE_CYCLES=4, then an_n=11 -> no acceptance; state stays S_UNITS.
REQ-035 Units 11110000 held 6 cycles, then legal tens -> one frame_err pulse, out_valid stays 0.
REQ-036 out_ready=0, frames 12 then 37 -> out_value=37, out_valid=1, overrun=1; raising out_ready clears out_valid the next edge.
REQ-037 Units 5 accepted, rst for 1 cycle, then only tens 3 -> all outputs 0, no out_valid.
REQ-038 CHANGE_ONLY=1, frame 42 displayed continuously for 3 frame periods -> exactly one out_valid assertion.
